// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch stage feeding the decoder.
// Holds the fetch PC and issues one 32-bit fetch per request to the memory
// controller. Predicts the next PC by following JAL statically and looking
// up conditional branches in a 2-bit branch history table. Each fetched word
// is presented to the decoder for exactly one cycle. A rollback redirects the
// PC and discards any response still in flight.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes all state and outputs
//   rollback          flush from ROB, with redirect target rollback_pc
//   rob_full, rs_full, lsb_full  downstream back-pressure, sampled at fetch start
//   mc_en, mc_pc      fetch request (level) and address to memory controller
//   mc_done, mc_data  one-cycle response strobe and fetched word
//   inst_rdy, inst, inst_pc, inst_pred_jump  one-cycle instruction to decoder
//   br_update, br_pc, br_taken  resolved branch outcome for BHT training
module inst_fetcher #(
   parameter int unsigned BHT_IDX_W = 8,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [31:0] rollback_pc,
   input  logic        rob_full,
   input  logic        rs_full,
   input  logic        lsb_full,
   output logic        mc_en,
   output logic [31:0] mc_pc,
   input  logic        mc_done,
   input  logic [31:0] mc_data,
   output logic        inst_rdy,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_pred_jump,
   input  logic        br_update,
   input  logic [31:0] br_pc,
   input  logic        br_taken
);

   localparam int unsigned BHT_N  = 1 << BHT_IDX_W;
   localparam logic [6:0]  OP_JAL = 7'b1101111;
   localparam logic [6:0]  OP_BR  = 7'b1100011;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      DISCARD  = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_mc_en, w_mc_en_nxt;
   logic [31:0] r_mc_pc, w_mc_pc_nxt;
   logic        r_inst_rdy, w_inst_rdy_nxt;
   logic [31:0] r_inst, w_inst_nxt;
   logic [31:0] r_inst_pc, w_inst_pc_nxt;
   logic        r_pred, w_pred_nxt;

   logic [1:0]  r_bht [BHT_N];

   logic [BHT_IDX_W-1:0] w_idx;
   logic [BHT_IDX_W-1:0] w_upd_idx;
   logic [31:0]          w_jal_imm;
   logic [31:0]          w_br_imm;
   logic                 w_is_jal;
   logic                 w_is_br;
   logic                 w_br_pred;
   logic                 w_taken;
   logic [31:0]          w_next_pc;
   logic                 w_full;
   logic                 w_unused_ok;

   assign mc_en          = r_mc_en;
   assign mc_pc          = r_mc_pc;
   assign inst_rdy       = r_inst_rdy;
   assign inst           = r_inst;
   assign inst_pc        = r_inst_pc;
   assign inst_pred_jump = r_pred;

   // Only the index bits of the resolved branch PC address the table.
   assign w_unused_ok = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};

   assign w_full    = rob_full | rs_full | lsb_full;
   assign w_idx     = r_pc[BHT_IDX_W+1:2];
   assign w_upd_idx = br_pc[BHT_IDX_W+1:2];

   // Next-PC prediction from the word being returned this cycle.
   assign w_jal_imm = {{11{mc_data[31]}}, mc_data[31], mc_data[19:12],
                       mc_data[20], mc_data[30:21], 1'b0};
   assign w_br_imm  = {{19{mc_data[31]}}, mc_data[31], mc_data[7],
                       mc_data[30:25], mc_data[11:8], 1'b0};
   assign w_is_jal  = (mc_data[6:0] == OP_JAL);
   assign w_is_br   = (mc_data[6:0] == OP_BR);
   // Lookup reads the registered counter, so a same-cycle update is not seen.
   assign w_br_pred = w_is_br & r_bht[w_idx][1];
   assign w_taken   = w_is_jal | w_br_pred;
   assign w_next_pc = r_pc + (w_is_jal  ? w_jal_imm :
                              w_br_pred ? w_br_imm  : 32'd4);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (rdy) begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_mc_en_nxt    = r_mc_en;
      w_mc_pc_nxt    = r_mc_pc;
      w_inst_rdy_nxt = 1'b0;
      w_inst_nxt     = r_inst;
      w_inst_pc_nxt  = r_inst_pc;
      w_pred_nxt     = r_pred;

      case (r_state)
         IDLE: begin
            if (rollback) begin
               w_pc_nxt = rollback_pc;
            end else if (!w_full) begin
               w_mc_en_nxt = 1'b1;
               w_mc_pc_nxt = r_pc;
               w_state_nxt = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (rollback) begin
               // A response landing with the rollback is simply dropped;
               // otherwise it is still owed and must be swallowed later.
               w_pc_nxt    = rollback_pc;
               w_mc_en_nxt = 1'b0;
               w_state_nxt = mc_done ? IDLE : DISCARD;
            end else if (mc_done) begin
               w_mc_en_nxt    = 1'b0;
               w_inst_nxt     = mc_data;
               w_inst_pc_nxt  = r_pc;
               w_inst_rdy_nxt = 1'b1;
               w_pred_nxt     = w_taken;
               w_pc_nxt       = w_next_pc;
               w_state_nxt    = IDLE;
            end
         end
         DISCARD: begin
            w_mc_en_nxt = 1'b0;
            if (rollback) begin
               w_pc_nxt = rollback_pc;
            end
            if (mc_done) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // PC and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_mc_en    <= 1'b0;
         r_mc_pc    <= 32'd0;
         r_inst_rdy <= 1'b0;
         r_inst     <= 32'd0;
         r_inst_pc  <= 32'd0;
         r_pred     <= 1'b0;
      end else if (rdy) begin
         r_pc       <= w_pc_nxt;
         r_mc_en    <= w_mc_en_nxt;
         r_mc_pc    <= w_mc_pc_nxt;
         r_inst_rdy <= w_inst_rdy_nxt;
         r_inst     <= w_inst_nxt;
         r_inst_pc  <= w_inst_pc_nxt;
         r_pred     <= w_pred_nxt;
      end
   end

   // Branch history table: saturating 2-bit counters, reset weakly not-taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(BHT_N); i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (rdy && br_update) begin
         if (br_taken) begin
            if (r_bht[w_upd_idx] != 2'b11) begin
               r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
            end
         end else begin
            if (r_bht[w_upd_idx] != 2'b00) begin
               r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed test-plan sequence followed by randomized traffic,
// checked every cycle against a behavioural model of the fetch stage.
module tb_inst_fetcher;

   localparam int K_OTHER = 0;
   localparam int K_JAL   = 1;
   localparam int K_BR    = 2;
   localparam int K_JALR  = 3;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, rob_full, rs_full, lsb_full;
   logic [31:0] rollback_pc;
   logic        mc_en, mc_done;
   logic [31:0] mc_pc, mc_data;
   logic        inst_rdy, inst_pred_jump;
   logic [31:0] inst, inst_pc;
   logic        br_update, br_taken;
   logic [31:0] br_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // Semantic description of the word currently on mc_data.
   int cur_kind = K_OTHER;
   int cur_off  = 0;

   inst_fetcher dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .rollback_pc(rollback_pc), .rob_full(rob_full), .rs_full(rs_full),
      .lsb_full(lsb_full), .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done),
      .mc_data(mc_data), .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
      .inst_pred_jump(inst_pred_jump), .br_update(br_update), .br_pc(br_pc),
      .br_taken(br_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_jal(input int off, input logic [4:0] rd);
      logic [31:0] o;
      o = 32'(off);
      return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_br(input int off, input logic [12:0] mid);
      logic [31:0] o;
      o = 32'(off);
      return {o[12], o[10:5], mid, o[4:1], o[11], 7'b1100011};
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 = free, 1 = request outstanding, 2 = dropping a stale response
   logic        m_valid = 1'b0;
   int          m_phase;
   logic [31:0] m_pc;
   int          m_bht [256];
   logic        e_mc_en, e_inst_rdy, e_pred;
   logic [31:0] e_mc_pc, e_inst, e_inst_pc;

   always @(posedge clk) begin : model
      int  idx;
      logic taken;
      if (rst) begin
         m_valid = 1'b1;
         m_phase = 0;
         m_pc = 32'h0;
         e_mc_en = 1'b0; e_mc_pc = 32'h0; e_inst_rdy = 1'b0;
         e_inst = 32'h0; e_inst_pc = 32'h0; e_pred = 1'b0;
         for (int i = 0; i < 256; i++) m_bht[i] = 1;
      end else if (rdy && m_valid) begin
         idx = int'(m_pc[9:2]);
         e_inst_rdy = 1'b0;
         if (m_phase == 0) begin
            if (rollback) m_pc = rollback_pc;
            else if (!(rob_full || rs_full || lsb_full)) begin
               e_mc_en = 1'b1; e_mc_pc = m_pc; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (rollback) begin
               m_pc = rollback_pc;
               e_mc_en = 1'b0;
               m_phase = mc_done ? 0 : 2;
            end else if (mc_done) begin
               taken = (cur_kind == K_JAL) || (cur_kind == K_BR && m_bht[idx] >= 2);
               e_inst = mc_data; e_inst_pc = m_pc; e_inst_rdy = 1'b1; e_pred = taken;
               m_pc = taken ? m_pc + 32'(cur_off) : m_pc + 32'd4;
               e_mc_en = 1'b0;
               m_phase = 0;
            end
         end else begin
            if (rollback) m_pc = rollback_pc;
            if (mc_done) m_phase = 0;
         end
         if (br_update) begin
            idx = int'(br_pc[9:2]);
            if (br_taken && m_bht[idx] < 3) m_bht[idx]++;
            else if (!br_taken && m_bht[idx] > 0) m_bht[idx]--;
         end
      end
   end

   logic in_random = 1'b0;
   int   n_rand_insts = 0;

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("mc_en", 32'(mc_en), 32'(e_mc_en));
         chk("mc_pc", mc_pc, e_mc_pc);
         chk("inst_rdy", 32'(inst_rdy), 32'(e_inst_rdy));
         chk("inst", inst, e_inst);
         chk("inst_pc", inst_pc, e_inst_pc);
         chk("inst_pred_jump", 32'(inst_pred_jump), 32'(e_pred));
         if (in_random && inst_rdy === 1'b1) n_rand_insts++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic clk1();
      @(posedge clk);
      #1;
      mc_done = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] d, input int kind, input int off, input int lat);
      repeat (lat) clk1();
      mc_done = 1'b1; mc_data = d; cur_kind = kind; cur_off = off;
      clk1();
   endtask

   task automatic redirect(input logic [31:0] pc);
      rollback = 1'b1; rollback_pc = pc;
      clk1();
      rollback = 1'b0;
      clk1();
   endtask

   localparam logic [31:0] ADDI = 32'h00000013;
   localparam logic [31:0] BEQ  = 32'hFE000EE3;

   initial begin : stim
      logic        busy;
      int          cnt, pk, po;
      logic [31:0] pd, r;

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = 32'h0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      mc_done = 1'b0; mc_data = 32'h0;
      br_update = 1'b0; br_pc = 32'h0; br_taken = 1'b0;
      #1;
      clk1(); clk1();
      chk("rst_mc_en", 32'(mc_en), 32'd0);
      chk("rst_mc_pc", mc_pc, 32'h0);
      chk("rst_inst_rdy", 32'(inst_rdy), 32'd0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      rst = 1'b0;
      clk1();
      chk("first_req_en", 32'(mc_en), 32'd1);
      chk("first_req_pc", mc_pc, 32'h0);
      fetch(ADDI, K_OTHER, 0, 2);
      chk("addi_rdy", 32'(inst_rdy), 32'd1);
      chk("addi_inst", inst, ADDI);
      chk("addi_pc", inst_pc, 32'h0);
      chk("addi_pred", 32'(inst_pred_jump), 32'd0);
      clk1();
      chk("addi_pulse", 32'(inst_rdy), 32'd0);
      chk("addi_next", mc_pc, 32'h4);
      fetch(ADDI, K_OTHER, 0, 0);
      clk1();
      chk("pc8_req", mc_pc, 32'h8);
      fetch(32'h0100006F, K_JAL, 16, 1);
      chk("jal_pred", 32'(inst_pred_jump), 32'd1);
      chk("jal_pc", inst_pc, 32'h8);
      clk1();
      chk("jal_target", mc_pc, 32'h18);
      fetch(ADDI, K_OTHER, 0, 0);
      redirect(32'h20);
      chk("redir_20", mc_pc, 32'h20);
      fetch(BEQ, K_BR, -4, 1);
      chk("br_weak_nt", 32'(inst_pred_jump), 32'd0);
      clk1();
      chk("br_nt_next", mc_pc, 32'h24);
      br_update = 1'b1; br_pc = 32'h20; br_taken = 1'b1;
      clk1(); clk1();
      br_update = 1'b0;
      fetch(ADDI, K_OTHER, 0, 0);
      redirect(32'h20);
      fetch(BEQ, K_BR, -4, 1);
      chk("br_trained", 32'(inst_pred_jump), 32'd1);
      clk1();
      chk("br_t_next", mc_pc, 32'h1C);
      br_update = 1'b1; br_taken = 1'b1;
      repeat (3) clk1();
      br_taken = 1'b0;
      clk1();
      br_update = 1'b0;
      fetch(ADDI, K_OTHER, 0, 0);
      redirect(32'h20);
      fetch(BEQ, K_BR, -4, 1);
      chk("br_sat", 32'(inst_pred_jump), 32'd1);
      // Rollback two cycles into an outstanding fetch.
      clk1();
      chk("rb_req", mc_pc, 32'h1C);
      clk1();
      rollback = 1'b1; rollback_pc = 32'h100;
      clk1();
      rollback = 1'b0;
      chk("rb_en_drop", 32'(mc_en), 32'd0);
      clk1();
      mc_done = 1'b1; mc_data = enc_jal(8, 5'd1); cur_kind = K_JAL; cur_off = 8;
      clk1();
      chk("stale_drop", 32'(inst_rdy), 32'd0);
      clk1();
      chk("rb_new_en", 32'(mc_en), 32'd1);
      chk("rb_new_pc", mc_pc, 32'h100);
      // Rollback coincident with the response.
      clk1();
      mc_done = 1'b1; mc_data = ADDI; cur_kind = K_OTHER; cur_off = 0;
      rollback = 1'b1; rollback_pc = 32'h200;
      clk1();
      rollback = 1'b0;
      chk("coinc_rdy", 32'(inst_rdy), 32'd0);
      clk1();
      chk("coinc_en", 32'(mc_en), 32'd1);
      chk("coinc_pc", mc_pc, 32'h200);
      // Back-pressure at fetch start.
      fetch(ADDI, K_OTHER, 0, 0);
      rob_full = 1'b1;
      repeat (5) begin
         clk1();
         chk("full_hold", 32'(mc_en), 32'd0);
      end
      rob_full = 1'b0;
      clk1();
      chk("full_rel_en", 32'(mc_en), 32'd1);
      chk("full_rel_pc", mc_pc, 32'h204);
      // Freeze mid-fetch.
      clk1();
      rdy = 1'b0;
      repeat (3) begin
         clk1();
         chk("frz_en", 32'(mc_en), 32'd1);
         chk("frz_pc", mc_pc, 32'h204);
      end
      rdy = 1'b1;
      fetch(ADDI, K_OTHER, 0, 0);
      chk("frz_done", inst_pc, 32'h204);

      // Randomized traffic with a well-behaved memory controller.
      in_random = 1'b1;
      busy = 1'b0; cnt = 0; pk = 0; po = 0; pd = 32'h0;
      for (int c = 0; c < 6000; c++) begin
         clk1();
         rdy = ($urandom_range(7) != 0);
         if (!busy && mc_en) begin
            busy = 1'b1;
            cnt = $urandom_range(3);
            pk = $urandom_range(3);
            r = $urandom;
            po = 0;
            case (pk)
               K_JAL: begin po = (int'($urandom_range(511)) - 256) * 4; pd = enc_jal(po, r[11:7]); end
               K_BR:  begin po = (int'($urandom_range(127)) - 64) * 4;  pd = enc_br(po, r[24:12]); end
               K_JALR: pd = {r[31:7], 7'b1100111};
               default: pd = {r[31:7], 7'b0010011};
            endcase
         end
         if (busy && rdy) begin
            if (cnt == 0) begin
               mc_done = 1'b1; mc_data = pd; cur_kind = pk; cur_off = po;
               busy = 1'b0;
            end else begin
               cnt--;
            end
         end
         rollback    = ($urandom_range(15) == 0);
         rollback_pc = 32'($urandom_range(255)) << 2;
         rob_full    = ($urandom_range(7) == 0);
         rs_full     = ($urandom_range(7) == 0);
         lsb_full    = ($urandom_range(7) == 0);
         br_update   = ($urandom_range(2) == 0);
         br_pc       = 32'($urandom_range(255)) << 2;
         br_taken    = 1'($urandom_range(1));
      end
      clk1();
      chk("rand_progress", 32'(n_rand_insts > 100), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Holds the architectural fetch PC and fetches one 32-bit instruction word per request through a request/done handshake with the memory controller.
- Predicts control flow with static JAL follow and a 2-bit branch history table (BHT), then presents each instruction for exactly one cycle as inst_rdy/inst/inst_pc/inst_pred_jump.
- Redirects on rollback and discards any in-flight stale response.

Parameters:
- BHT_IDX_W, 8, log2 of BHT entries; index = pc[BHT_IDX_W+1:2].
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = freeze all state, outputs hold
- rollback  in  1  mispredict flush from ROB
- rollback_pc  in  32  redirect target
- rob_full  in  1  ROB has <=1 free slot
- rs_full  in  1  reservation station has <=1 free slot
- lsb_full  in  1  load/store buffer has <=1 free slot
- mc_en  out  1  fetch request to memory controller (level, held until mc_done)
- mc_pc  out  32  fetch address
- mc_done  in  1  one-cycle pulse: mc_data valid
- mc_data  in  32  fetched instruction word
- inst_rdy  out  1  one-cycle pulse: instruction valid to decoder
- inst  out  32  instruction word
- inst_pc  out  32  its PC
- inst_pred_jump  out  1  predicted taken (JAL or BHT taken)
- br_update  in  1  branch resolved (from ROB commit)
- br_pc  in  32  resolved branch PC
- br_taken  in  1  actual outcome

Behaviour:
- Reset: pc=RESET_PC, state=IDLE; mc_en=0, mc_pc=0, inst_rdy=0, inst=0, inst_pc=0, inst_pred_jump=0; all BHT counters=2'b01 (weakly not-taken). rst overrides rdy and mid-flight fetch; no discard follows reset.
- States: IDLE, WAIT_MEM, DISCARD.
- IDLE: if !rollback and !(rob_full|rs_full|lsb_full), set mc_en<=1, mc_pc<=pc, go to WAIT_MEM. Otherwise stay.
- WAIT_MEM, mc_done and !rollback: mc_en<=0; inst<=mc_data, inst_pc<=pc, inst_rdy<=1; pc<=next_pc; inst_pred_jump per prediction; go to IDLE.
- Throughput: one instruction per (mem latency + 2) cycles minimum.
- inst_rdy is a one-cycle pulse and is cleared every cycle it is not being set.
- Prediction, decoded from mc_data[6:0]:
  - 1101111 (JAL): taken; next_pc = pc + sext({d[31],d[19:12],d[20],d[30:21],1'b0}).
  - 1100011 (BR): taken iff BHT[pc idx][1]==1; then next_pc = pc + sext({d[31],d[7],d[30:25],d[11:8],1'b0}).
  - All others, including JALR: not taken; next_pc = pc+4.
  - Adds are 32-bit mod 2^32; wrap is ignored.
- Rollback, any state (when rdy):
  - pc<=rollback_pc, inst_rdy<=0.
  - IDLE: stay IDLE.
  - WAIT_MEM with mc_done in the same cycle: response dropped, mc_en<=0, IDLE.
  - WAIT_MEM without mc_done: mc_en<=0, go to DISCARD.
- DISCARD: mc_en=0; wait for the stale mc_done, drop it, then go to IDLE. A further rollback in DISCARD only updates pc.
- Memory controller contract: a request, once issued, always completes with exactly one mc_done.
- BHT update, on br_update when rdy: counter at br_pc[BHT_IDX_W+1:2] saturating +1 if br_taken, -1 otherwise (range 00..11). Update is independent of rollback and state. A same-cycle lookup of the same index sees the pre-update value.
- Full flags are sampled only at fetch start; the downstream units reserve the one slot for the in-flight instruction.
- rdy=0: no state, BHT, or output changes; mc_done arriving while rdy=0 is not supported (controller shares rdy).

Test Plan:
- Reset, then mc_done after 3 cycles with data 32'h00000013 (addi) at pc 0 -> mc_en rises cycle 1, mc_pc=0; inst_rdy pulses once with inst_pc=0, pred=0; next mc_pc=4.
- Fetch JAL 32'h0100006F at pc 8 -> inst_pred_jump=1; next mc_pc=0x18.
- Branch 32'hFE000EE3 (beq, imm -4) at pc 0x20, BHT reset state -> not taken, next 0x24. Apply two br_update taken for br_pc=0x20, refetch -> pred=1, next 0x1C. Saturate with 3 taken then 1 not-taken -> still predicts taken.
- Rollback to 0x100 two cycles into WAIT_MEM -> mc_en drops; stale mc_done ignored (no inst_rdy); next request mc_pc=0x100.
- Rollback coincident with mc_done -> no inst_rdy; IDLE; next mc_pc=rollback_pc, with no DISCARD wait.
- rob_full=1 in IDLE for 5 cycles -> mc_en stays 0. Deassert -> request next cycle. rdy=0 mid-WAIT_MEM -> all outputs frozen.
